// File: rtl/lut_sched_pkg.sv
// lut_sched_pkg: shared types and helpers for the LUT layer scheduler.
// FSM state encoding, config-select constants, table address packing.
package lut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    OUT
  } state_e;

  localparam logic CFG_SEL_TABLE = 1'b0;
  localparam logic CFG_SEL_CONN  = 1'b1;

  function automatic int unsigned pack_addr(
    input int unsigned nrn,
    input int unsigned lut,
    input int unsigned aw
  );
    return (nrn << aw) | lut;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// lut_table_ram: single-write, synchronous-read distributed RAM.
// Holds every neuron's truth table; contents are never reset.
module lut_table_ram #(
  parameter int DW = 2,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // write port plus registered read port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lut_layer_sched.sv
// lut_layer_sched: serial evaluation of one LUT-neuron layer.
// Define LUT_SCHED_PERF_EN to add perf_frames/perf_stall counters.
module lut_layer_sched
  import lut_sched_pkg::*;
#(
  parameter int ACT_W  = 2,
  parameter int FAN_IN = 4,
  parameter int N_IN   = 16,
  parameter int N_OUT  = 16,
  parameter int IDX_W  = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*ACT_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*ACT_W-1:0]   out_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_sel,
  input  logic [$clog2(N_OUT)+FAN_IN*ACT_W-1:0] cfg_addr,
  input  logic [IDX_W-1:0]         cfg_data
`ifdef LUT_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_frames,
  output logic [31:0]              perf_stall
`endif
);

  localparam int AW = FAN_IN * ACT_W;
  localparam int NB = $clog2(N_OUT);
  localparam int SB = $clog2(FAN_IN);
  localparam int TW = NB + AW;
  localparam logic [NB:0]   CNT_END = (NB+1)'(N_OUT);
  localparam logic [NB-1:0] LAST    = NB'(N_OUT - 1);

  state_e                 state_q, state_d;
  logic [NB:0]            cnt_q, cnt_d;
  logic [N_IN*ACT_W-1:0]  in_q;
  logic [N_OUT*ACT_W-1:0] out_q;
  logic [IDX_W-1:0]       conn_q [N_OUT][FAN_IN];
  logic                   rv_q, rv_d;
  logic [NB-1:0]          ridx_q;
  logic [AW-1:0]          lut_addr;
  logic [TW-1:0]          raddr;
  logic [ACT_W-1:0]       rdata;
  logic                   in_fire, cfg_fire;
  logic                   tbl_we, conn_we;

  assign in_fire  = in_valid & in_ready;
  assign cfg_fire = (state_q == IDLE) & cfg_valid;
  assign tbl_we   = cfg_fire & (cfg_sel == CFG_SEL_TABLE);
  assign conn_we  = cfg_fire & (cfg_sel == CFG_SEL_CONN);

  // gather the current neuron's fan-in activations into its LUT address
  always_comb begin
    lut_addr = '0;
    for (int s = 0; s < FAN_IN; s++) begin
      if (int'(conn_q[cnt_q[NB-1:0]][s]) < N_IN)
        lut_addr[s*ACT_W +: ACT_W] =
          in_q[int'(conn_q[cnt_q[NB-1:0]][s])*ACT_W +: ACT_W];
      else
        lut_addr[s*ACT_W +: ACT_W] = in_q[ACT_W-1:0];
    end
  end

  assign raddr = TW'(pack_addr(32'(cnt_q[NB-1:0]), 32'(lut_addr), AW));

  lut_table_ram #(
    .DW(ACT_W),
    .AW(TW)
  ) u_ram (
    .clk  (clk),
    .we   (tbl_we),
    .waddr(cfg_addr),
    .wdata(cfg_data[ACT_W-1:0]),
    .raddr(raddr),
    .rdata(rdata)
  );

  // next state, counter and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    rv_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = ~cfg_valid;
        if (in_valid && !cfg_valid) begin
          state_d = EVAL;
          cnt_d   = '0;
        end
      end
      EVAL: begin
        if (cnt_q != CNT_END) begin
          cnt_d = cnt_q + 1'b1;
          rv_d  = 1'b1;
        end
        if (rv_q && ridx_q == LAST) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and read-pipeline tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      ridx_q  <= cnt_q[NB-1:0];
    end
  end

  // input vector capture and per-neuron result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      if (in_fire) in_q <= in_data;
      if (rv_q) out_q[int'(ridx_q)*ACT_W +: ACT_W] <= rdata;
    end
  end

  // connectivity table, written only from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_OUT; n++)
        for (int s = 0; s < FAN_IN; s++)
          conn_q[n][s] <= '0;
    end else if (conn_we) begin
      conn_q[cfg_addr[SB +: NB]][cfg_addr[SB-1:0]] <= cfg_data;
    end
  end

  assign out_data = out_q;

`ifdef LUT_SCHED_PERF_EN
  logic [31:0] frames_q, stall_q;

  // output handshakes and back-pressure cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else if (state_q == OUT) begin
      if (out_ready) frames_q <= frames_q + 32'd1;
      else           stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_frames = frames_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
// tb_lut_layer_sched: scoreboard bench for lut_layer_sched.
// Random stimulus checked against a table/array reference model.
module tb_lut_layer_sched;

  localparam int ACT_W  = 2;
  localparam int FAN_IN = 4;
  localparam int N_IN   = 16;
  localparam int N_OUT  = 16;
  localparam int LAT    = N_OUT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        cfg_valid, cfg_ready, cfg_sel;
  logic [11:0] cfg_addr;
  logic [3:0]  cfg_data;
`ifdef LUT_SCHED_PERF_EN
  logic [31:0] perf_frames, perf_stall;
`endif

  typedef struct {
    logic [31:0] d;
    int          hs;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  bit         have = 0;
  bit         prev_ov = 0;
  logic [1:0] tbl_m [N_OUT][256];
  int         conn_m [N_OUT][FAN_IN];
  int         vecs = 0;
  int         errs = 0;
  int         cyc = 0;
  int         rdy_mode = 0;

  lut_layer_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data)
`ifdef LUT_SCHED_PERF_EN
    ,
    .perf_frames(perf_frames),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] din);
    logic [31:0] r;
    logic [1:0]  v;
    int          a, src;
    r = '0;
    for (int n = 0; n < N_OUT; n++) begin
      a = 0;
      for (int s = 0; s < FAN_IN; s++) begin
        src = conn_m[n][s];
        v = (src < N_IN) ? din[src*ACT_W +: ACT_W] : din[ACT_W-1:0];
        a += int'(v) << (s * ACT_W);
      end
      r[n*ACT_W +: ACT_W] = tbl_m[n][a];
    end
    return r;
  endfunction

  // monitor: pops the scoreboard on each new result frame
  always @(negedge clk) begin
    if (!rst_n) begin
      have    = 0;
      prev_ov = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          cur  = sb.pop_front();
          have = 1;
          chk("latency", 64'(cyc - cur.hs), 64'(LAT));
        end
      end
      if (out_valid && have) begin
        chk("out_data", 64'(out_data), 64'(cur.d));
        chk("in_ready_in_out", 64'(in_ready), 64'd0);
        chk("cfg_ready_in_out", 64'(cfg_ready), 64'd0);
      end
      if (out_valid && out_ready) have = 0;
      prev_ov = out_valid;
    end
  end

  task automatic cfg_wr(input bit sel, input int addr, input int data);
    int k;
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr[11:0];
    cfg_data  = data[3:0];
    k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cfg_ready) begin
      chk("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
    end else if (!sel) begin
      tbl_m[(addr >> 8) & 15][addr & 255] = data[1:0];
    end else begin
      conn_m[(addr >> 2) & 15][addr & 3] = data;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, output int waited);
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    else sb.push_back('{model(d), cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("drain_idle", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          w, k;
    logic [31:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    for (int n = 0; n < N_OUT; n++)
      for (int s = 0; s < FAN_IN; s++) conn_m[n][s] = 0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    for (int n = 0; n < N_OUT; n++)
      for (int s = 0; s < FAN_IN; s++) cfg_wr(1'b1, n*4 + s, n);
    for (int n = 0; n < N_OUT; n++)
      for (int a = 0; a < 256; a++) cfg_wr(1'b0, n*256 + a, a & 3);

    d = '0;
    for (int i = 0; i < N_IN; i++) d[i*ACT_W +: ACT_W] = 2'(i % 4);
    send(d, w);
    wait_idle();

    for (int a = 0; a < 256; a++) cfg_wr(1'b0, 3*256 + a, (a == 255) ? 3 : 0);
    cfg_wr(1'b1, 3*4 + 0, 5);
    cfg_wr(1'b1, 3*4 + 1, 9);
    cfg_wr(1'b1, 3*4 + 2, 12);
    cfg_wr(1'b1, 3*4 + 3, 14);
    d = $urandom();
    d[10 +: 2] = 2'd3;
    d[18 +: 2] = 2'd3;
    d[24 +: 2] = 2'd3;
    d[28 +: 2] = 2'd3;
    send(d, w);
    d[18 +: 2] = 2'd2;
    send(d, w);
    wait_idle();

    for (int i = 0; i < 200; i++)
      cfg_wr(1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
    for (int i = 0; i < 30; i++)
      cfg_wr(1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) send($urandom(), w);
    wait_idle();
    rdy_mode = 0;

    rdy_mode = 1;
    send($urandom(), w);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_sel   = 1'b1;
    cfg_addr  = 12'd0;
    cfg_data  = 4'(conn_m[0][0] ^ 5);
    repeat (10) begin
      @(negedge clk);
      chk("bp_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    rdy_mode  = 0;
    k = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    d = $urandom();
    send(d, w);
    wait_idle();

    in_data   = $urandom();
    in_valid  = 1'b1;
    cfg_valid = 1'b1;
    cfg_sel   = 1'b1;
    cfg_addr  = 12'(2*4 + 0);
    cfg_data  = 4'(conn_m[2][0] ^ 7);
    @(negedge clk);
    chk("sim_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("sim_in_ready", 64'(in_ready), 64'd0);
    if (cfg_ready) conn_m[2][0] = int'(cfg_data);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    send(in_data, w);
    chk("sim_in_wait", 64'(w), 64'd0);
    wait_idle();

    send($urandom(), w);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    for (int n = 0; n < N_OUT; n++)
      for (int s = 0; s < FAN_IN; s++) conn_m[n][s] = 0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("abort_no_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send($urandom(), w);
    wait_idle();
    for (int i = 0; i < 20; i++)
      cfg_wr(1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
    send($urandom(), w);
    send($urandom(), w);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
